frame_seq_ctrl: RTL and testbench

//  Multi-frame MDCT->IMDCT sequencer. Walks num_frames audio frames from start_music_addr in FRAME_STEP strides.
//  For each frame it starts the MDCT core, waits for it to finish, then starts the IMDCT core and waits again.

---
 rtl/frame_seq_ctrl_pkg.sv | 22 ++
 rtl/frame_seq_ctrl_if.sv | 22 ++
 rtl/frame_seq_ctrl_watchdog.sv | 32 +++
 rtl/frame_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_frame_seq_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/frame_seq_ctrl_pkg.sv
// rtl/frame_seq_ctrl_pkg.sv - shared state encoding and default widths for the frame sequencer
package audio_ctrl_pkg;

  localparam int ADDR_W_DEF     = 14;
  localparam int CNT_W_DEF      = 8;
  localparam int TO_W_DEF       = 16;
  localparam int FRAME_STEP_DEF = 256;
  localparam int SETTLE_CYC_DEF = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_S_MDCT,
    ST_W_MDCT,
    ST_S_IMDCT,
    ST_W_IMDCT,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/frame_seq_ctrl_if.sv
// rtl/frame_seq_ctrl_if.sv - sequencer to MDCT/IMDCT core handshake bundle
interface frame_seq_ctrl_if #(
  parameter int ADDR_W = audio_ctrl_pkg::ADDR_W_DEF
);
  logic [ADDR_W-1:0] frame_addr;
  logic              start_mdct;
  logic              finish_mdct;
  logic              rstn_mdct;
  logic              start_imdct;
  logic              finish_imdct;
  logic              rstn_imdct;

  modport master (
    output frame_addr, start_mdct, rstn_mdct, start_imdct, rstn_imdct,
    input  finish_mdct, finish_imdct
  );

  modport slave (
    input  frame_addr, start_mdct, rstn_mdct, start_imdct, rstn_imdct,
    output finish_mdct, finish_imdct
  );
endinterface

// File: rtl/frame_seq_ctrl_watchdog.sv
// rtl/frame_seq_ctrl_watchdog.sv - saturating per-run completion watchdog
module ctrl_watchdog #(
  parameter int TO_W = audio_ctrl_pkg::TO_W_DEF
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [TO_W-1:0] lim,
  output logic            expired
);
  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {TO_W{1'b1}})) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (lim != '0) && (cnt_q == lim);
endmodule

// File: rtl/frame_seq_ctrl.sv
// rtl/frame_seq_ctrl.sv - multi-frame MDCT->IMDCT sequencer with watchdog, abort and sticky status
module frame_seq_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FRAME_STEP = FRAME_STEP_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int TO_W       = TO_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start_sys,
  input  logic              intr_clr_sys,
  input  logic              abort_sys,
  input  logic [ADDR_W-1:0] start_music_addr,
  input  logic [CNT_W-1:0]  num_frames,
  input  logic [TO_W-1:0]   timeout_lim,
  output logic              start_clr_sys,
  output logic              intr_sys,
  output logic              err_sys,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_idx,
  frame_seq_ctrl_if.master  core
);
  localparam int SW = $clog2(SETTLE_CYC + 1);

  state_e            state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TO_W-1:0]   lim_q, lim_d;
  logic              start_clr_q, start_clr_d;
  logic              intr_q, intr_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              rstn_q, rstn_d;
  logic              start_mdct_q, start_mdct_d;
  logic              start_imdct_q, start_imdct_d;
  logic              wd_clr, wd_en, wd_expired;

  ctrl_watchdog #(.TO_W(TO_W)) u_watchdog (
    .clk_in  (clk_in),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .lim     (lim_q),
    .expired (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    settle_d      = settle_q;
    count_d       = count_q;
    idx_d         = idx_q;
    addr_d        = addr_q;
    lim_d         = lim_q;
    start_clr_d   = 1'b0;
    start_mdct_d  = 1'b0;
    start_imdct_d = 1'b0;
    intr_d        = intr_q;
    err_d         = err_q;
    // Clear is applied first so a coincident DONE/ERROR set wins.
    if (intr_clr_sys) begin
      intr_d = 1'b0;
      err_d  = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (start_sys && !intr_q) begin
          addr_d      = start_music_addr;
          count_d     = (num_frames == '0) ? CNT_W'(1) : num_frames;
          lim_d       = timeout_lim;
          idx_d       = '0;
          err_d       = 1'b0;
          start_clr_d = 1'b1;
          settle_d    = '0;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          state_d = ST_S_MDCT;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_S_MDCT: begin
        start_mdct_d = 1'b1;
        state_d      = ST_W_MDCT;
      end
      ST_W_MDCT: begin
        if (wd_expired)       state_d = ST_ERROR;
        else if (core.finish_mdct) state_d = ST_S_IMDCT;
      end
      ST_S_IMDCT: begin
        start_imdct_d = 1'b1;
        state_d       = ST_W_IMDCT;
      end
      ST_W_IMDCT: begin
        if (wd_expired)        state_d = ST_ERROR;
        else if (core.finish_imdct) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q == count_q - CNT_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + CNT_W'(1);
          addr_d  = addr_q + ADDR_W'(FRAME_STEP);
          state_d = ST_S_MDCT;
        end
      end
      ST_DONE: begin
        intr_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        intr_d  = 1'b1;
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_sys && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      start_mdct_d  = 1'b0;
      start_imdct_d = 1'b0;
    end
    // Watchdog restarts on entry to each start state and counts through start+wait.
    wd_clr = (state_d == ST_S_MDCT) || (state_d == ST_S_IMDCT);
    wd_en  = state_q inside {ST_S_MDCT, ST_W_MDCT, ST_S_IMDCT, ST_W_IMDCT};
    busy_d = (state_d != ST_IDLE);
    rstn_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      settle_q      <= '0;
      count_q       <= '0;
      idx_q         <= '0;
      addr_q        <= '0;
      lim_q         <= '0;
      start_clr_q   <= 1'b0;
      intr_q        <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      rstn_q        <= 1'b0;
      start_mdct_q  <= 1'b0;
      start_imdct_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      addr_q        <= addr_d;
      lim_q         <= lim_d;
      start_clr_q   <= start_clr_d;
      intr_q        <= intr_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      rstn_q        <= rstn_d;
      start_mdct_q  <= start_mdct_d;
      start_imdct_q <= start_imdct_d;
    end
  end

  assign start_clr_sys    = start_clr_q;
  assign intr_sys         = intr_q;
  assign err_sys          = err_q;
  assign busy             = busy_q;
  assign frame_idx        = idx_q;
  assign core.frame_addr  = addr_q;
  assign core.start_mdct  = start_mdct_q;
  assign core.start_imdct = start_imdct_q;
  assign core.rstn_mdct   = rstn_q;
  assign core.rstn_imdct  = rstn_q;
endmodule

// File: tb/tb_frame_seq_ctrl.sv
// tb/tb_frame_seq_ctrl.sv - scoreboard bench for the frame sequencer
module tb_frame_seq_ctrl;
  import audio_ctrl_pkg::*;

  localparam int AW = 14;
  localparam int CW = 8;
  localparam int TW = 16;
  localparam int SETTLE = 2;
  localparam int STEP = 256;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          start_sys = 1'b0;
  logic          intr_clr_sys = 1'b0;
  logic          abort_sys = 1'b0;
  logic [AW-1:0] start_music_addr = '0;
  logic [CW-1:0] num_frames = '0;
  logic [TW-1:0] timeout_lim = '0;
  logic          start_clr_sys, intr_sys, err_sys, busy;
  logic [CW-1:0] frame_idx;

  logic fm_auto = 1'b0, fi_auto = 1'b0, fi_spur = 1'b0;
  logic resp_m_en = 1'b1, resp_i_en = 1'b1;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, fin_cyc = 0, n_mdct = 0, n_imdct = 0;
  logic [CW+AW-1:0] exp_m[$];
  logic [CW+AW-1:0] exp_i[$];

  frame_seq_ctrl_if #(.ADDR_W(AW)) core();
  assign core.finish_mdct  = fm_auto;
  assign core.finish_imdct = fi_auto | fi_spur;

  frame_seq_ctrl #(
    .ADDR_W(AW), .CNT_W(CW), .FRAME_STEP(STEP), .SETTLE_CYC(SETTLE), .TO_W(TW)
  ) dut (
    .clk_in           (clk_in),
    .rst              (rst),
    .start_sys        (start_sys),
    .intr_clr_sys     (intr_clr_sys),
    .abort_sys        (abort_sys),
    .start_music_addr (start_music_addr),
    .num_frames       (num_frames),
    .timeout_lim      (timeout_lim),
    .start_clr_sys    (start_clr_sys),
    .intr_sys         (intr_sys),
    .err_sys          (err_sys),
    .busy             (busy),
    .frame_idx        (frame_idx),
    .core             (core)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_in);
  endtask

  // Core models: finish pulse 5 cycles after each observed start.
  initial forever begin
    @(negedge clk_in);
    if (core.start_mdct && resp_m_en) begin
      repeat (5) @(posedge clk_in);
      #1 fm_auto = 1'b1;
      @(posedge clk_in);
      #1 fm_auto = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk_in);
    if (core.start_imdct && resp_i_en) begin
      repeat (5) @(posedge clk_in);
      #1 fi_auto = 1'b1;
      @(posedge clk_in);
      #1 fi_auto = 1'b0;
    end
  end

  always @(negedge clk_in) begin
    if (core.start_mdct) begin
      n_mdct++;
      if (exp_m.size() == 0) chk("mdct_extra", 1, 0);
      else chk("mdct_frame", 32'({frame_idx, core.frame_addr}), 32'(exp_m.pop_front()));
    end
    if (core.start_imdct) begin
      n_imdct++;
      chk("fin2imdct_lat", cyc - fin_cyc, 2);
      if (exp_i.size() == 0) chk("imdct_extra", 1, 0);
      else chk("imdct_frame", 32'({frame_idx, core.frame_addr}), 32'(exp_i.pop_front()));
    end
    if (core.finish_mdct) fin_cyc = cyc;
  end

  task automatic push_frames(input logic [AW-1:0] a, input int nm, input int ni);
    logic [AW-1:0] ai;
    ai = a;
    for (int i = 0; i < nm || i < ni; i++) begin
      if (i < nm) exp_m.push_back({CW'(i), ai});
      if (i < ni) exp_i.push_back({CW'(i), ai});
      ai = ai + AW'(STEP);
    end
  endtask

  task automatic start_run(input logic [AW-1:0] a, input logic [CW-1:0] nf,
                           input logic [TW-1:0] lim);
    start_music_addr = a;
    num_frames       = nf;
    timeout_lim      = lim;
    start_sys        = 1'b1;
    tick();
    start_sys = 1'b0;
    chk("start_clr_hi", start_clr_sys, 1);
    chk("busy_after_accept", busy, 1);
    chk("rstn_after_accept", core.rstn_mdct & core.rstn_imdct, 1);
    tick();
    chk("start_clr_lo", start_clr_sys, 0);
  endtask

  task automatic wait_intr(input string tag, input int budget);
    for (int i = 0; i < budget && !intr_sys; i++) tick();
    chk(tag, intr_sys, 1);
  endtask

  initial begin
    int k, base_m, base_i, w0;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_intr_err", {intr_sys, err_sys}, 0);
    chk("rst_rstn", {core.rstn_mdct, core.rstn_imdct}, 0);
    chk("rst_pulses", {start_clr_sys, core.start_mdct, core.start_imdct}, 0);
    chk("rst_idx_addr", 32'({frame_idx, core.frame_addr}), 0);
    rst = 1'b0;
    tick();

    // Three frames from 0x100
    base_m = n_mdct; base_i = n_imdct;
    push_frames(14'h100, 3, 3);
    start_run(14'h100, 8'd3, 16'd0);
    k = 0;
    while (!core.start_mdct && k < 20) begin tick(); k++; end
    chk("accept2mdct_lat", 2 + k, SETTLE + 2);
    wait_intr("t1_done", 300);
    chk("t1_busy", busy, 0);
    chk("t1_err", err_sys, 0);
    chk("t1_rstn", {core.rstn_mdct, core.rstn_imdct}, 0);
    chk("t1_n_mdct", n_mdct - base_m, 3);
    chk("t1_n_imdct", n_imdct - base_i, 3);
    chk("t1_sb_empty", exp_m.size() + exp_i.size(), 0);

    // Zero frames behaves as one
    intr_clr_sys = 1'b1; tick(); intr_clr_sys = 1'b0;
    chk("t2_clr", intr_sys, 0);
    base_m = n_mdct; base_i = n_imdct;
    push_frames(14'h040, 1, 1);
    start_run(14'h040, 8'd0, 16'd100);
    wait_intr("t2_done", 200);
    tick(10);
    chk("t2_n_mdct", n_mdct - base_m, 1);
    chk("t2_n_imdct", n_imdct - base_i, 1);
    chk("t2_sb_empty", exp_m.size() + exp_i.size(), 0);

    // Start ignored while the interrupt is pending
    start_sys = 1'b1;
    tick(3);
    chk("t5_ignored_clr", start_clr_sys, 0);
    chk("t5_ignored_busy", busy, 0);
    start_sys = 1'b0;
    intr_clr_sys = 1'b1; tick(); intr_clr_sys = 1'b0;
    chk("t5_intr_cleared", intr_sys, 0);

    // Watchdog timeout with an unresponsive MDCT
    resp_m_en = 1'b0;
    base_i = n_imdct;
    push_frames(14'h500, 1, 0);
    start_run(14'h500, 8'd1, 16'd10);
    k = 0;
    while (!core.start_mdct && k < 20) begin tick(); k++; end
    chk("t3_mdct_seen", core.start_mdct, 1);
    w0 = cyc;
    for (int i = 0; i < 40 && !err_sys; i++) tick();
    chk("t3_timeout_lat", cyc - w0, 11);
    chk("t3_flags", {err_sys, intr_sys}, 2'b11);
    chk("t3_rstn", {core.rstn_mdct, core.rstn_imdct}, 0);
    chk("t3_busy", busy, 0);
    chk("t3_no_imdct", n_imdct - base_i, 0);
    resp_m_en = 1'b1;
    intr_clr_sys = 1'b1; tick(); intr_clr_sys = 1'b0;
    chk("t3_clr", {err_sys, intr_sys}, 0);

    // Abort while waiting on IMDCT of frame 1
    base_m = n_mdct; base_i = n_imdct;
    push_frames(14'h800, 2, 2);
    start_run(14'h800, 8'd3, 16'd0);
    k = 0;
    while (!(core.start_imdct && frame_idx == 8'd1) && k < 200) begin tick(); k++; end
    chk("t4_reached_w_imdct", core.start_imdct, 1);
    abort_sys = 1'b1;
    tick();
    abort_sys = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_rstn", {core.rstn_mdct, core.rstn_imdct}, 0);
    chk("t4_intr", intr_sys, 0);
    tick(30);
    chk("t4_flags_after", {intr_sys, err_sys}, 0);
    chk("t4_n_mdct", n_mdct - base_m, 2);
    chk("t4_n_imdct", n_imdct - base_i, 2);
    chk("t4_sb_empty", exp_m.size() + exp_i.size(), 0);

    // Address wrap plus a stray IMDCT finish during the MDCT wait
    base_m = n_mdct; base_i = n_imdct;
    push_frames(14'h3F80, 2, 2);
    start_run(14'h3F80, 8'd2, 16'd0);
    k = 0;
    while (!core.start_mdct && k < 20) begin tick(); k++; end
    fi_spur = 1'b1;
    tick();
    fi_spur = 1'b0;
    wait_intr("t6_done", 300);
    chk("t6_last_addr", 32'(core.frame_addr), 32'h0080);
    chk("t6_n_mdct", n_mdct - base_m, 2);
    chk("t6_n_imdct", n_imdct - base_i, 2);
    chk("t6_sb_empty", exp_m.size() + exp_i.size(), 0);
    chk("t6_err", err_sys, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
